// File: rtl/seg_score_scanner_if.sv
// rtl/seg_score_scanner_if.sv - handshake/display bundle between game logic and the score scanner
interface seg_score_scanner_if #(
    parameter int VALUE_W = 14
);
    logic               scanTick;
    logic               valueLoad;
    logic [VALUE_W-1:0] value;
    logic               busy;
    logic [3:0]         an;
    logic [6:0]         seg;

    modport master (output scanTick, valueLoad, value, input busy, an, seg);
    modport slave  (input scanTick, valueLoad, value, output busy, an, seg);
endinterface

// File: rtl/seg_score_scanner.sv
// rtl/seg_score_scanner.sv - binary score to BCD (sequential double-dabble) with 4-digit 7-seg scan
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading-zero digits above the ones slot.
module seg_score_scanner #(
    parameter int VALUE_W   = 14,
    parameter int MAX_VALUE = 9999
) (
    input  logic               MasterClock,
    input  logic               Reset,
    seg_score_scanner_if.slave bus
);
    localparam int                 CNT_W     = $clog2(VALUE_W + 1);
    localparam logic [VALUE_W-1:0] MAX_V     = VALUE_W'(MAX_VALUE);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(VALUE_W - 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t             r_state;
    logic               r_busy;
    logic [VALUE_W-1:0] r_shift;
    logic [15:0]        r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pend;
    logic [VALUE_W-1:0] r_pend_val;
    logic [15:0]        r_digits;
    logic [1:0]         r_idx;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    logic [VALUE_W-1:0] w_load_val;
    logic [15:0]        w_bcd_adj;
    logic [15:0]        w_bcd_next;
    logic [VALUE_W-1:0] w_shift_next;
    logic [1:0]         w_idx_next;
    logic [3:0]         w_digit;
    logic               w_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign w_load_val = (bus.value > MAX_V) ? MAX_V : bus.value;

    // Add-3 correction on every nibble >= 5, then shift the next binary bit in
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < 4; i++) begin
            w_bcd_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? r_bcd[i*4 +: 4] + 4'd3
                                                            : r_bcd[i*4 +: 4];
        end
    end

    assign w_bcd_next   = {w_bcd_adj[14:0], r_shift[VALUE_W-1]};
    assign w_shift_next = {r_shift[VALUE_W-2:0], 1'b0};

    assign w_idx_next = r_idx + 2'd1;
    assign w_digit    = r_digits[{w_idx_next, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        case (w_idx_next)
            2'd3:    w_blank = (r_digits[15:12] == 4'd0);
            2'd2:    w_blank = (r_digits[15:8]  == 8'd0);
            2'd1:    w_blank = (r_digits[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_digits   <= '0;
            r_idx      <= 2'd3;
            r_an       <= 4'b1111;
            r_seg      <= 7'b1111111;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valueLoad || r_pend) begin
                        r_shift <= bus.valueLoad ? w_load_val : r_pend_val;
                        r_bcd   <= '0;
                        r_cnt   <= LAST_STEP;
                        r_pend  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_shift_next;
                    r_bcd   <= w_bcd_next;
                    if (r_cnt == '0) begin
                        r_digits <= w_bcd_next;
                        // A load in the final cycle is newer than any pending value
                        if (bus.valueLoad || r_pend) begin
                            r_shift <= bus.valueLoad ? w_load_val : r_pend_val;
                            r_bcd   <= '0;
                            r_cnt   <= LAST_STEP;
                            r_pend  <= 1'b0;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (bus.valueLoad) begin
                            r_pend     <= 1'b1;
                            r_pend_val <= w_load_val;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (bus.scanTick) begin
                r_idx <= w_idx_next;
                if (w_blank) begin
                    r_an  <= 4'b1111;
                    r_seg <= 7'b1111111;
                end else begin
                    r_an  <= ~(4'b0001 << w_idx_next);
                    r_seg <= decode(w_digit);
                end
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.an   = r_an;
    assign bus.seg  = r_seg;
endmodule
